// File: rtl/control_sequencer.sv
// Command sequencer for a three-register datapath: decodes LOADA/MOVAB/ADD/ACC into
// per-cycle register load strobes and bus-drive selects, with a completion pulse.
//
// state | meaning
// IDLE  | ready for a command, no strobes
// T1    | first micro-step of the latched op
// T2    | second micro-step (ADD, ACC); ACC loops T1/T2 while iterations remain
// FIN   | one-cycle done pulse, then back to IDLE
module control_sequencer #(
    parameter int CNT_W = 4
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [CNT_W-1:0] cmd_count,
    output logic             RAin,
    output logic             RBin,
    output logic             RZin,
    output logic             RAout,
    output logic             RBout,
    output logic             RZout,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {IDLE, T1, T2, FIN} state_t;
    typedef enum logic [1:0] {OP_LOADA = 2'b00, OP_MOVAB = 2'b01,
                              OP_ADD = 2'b10, OP_ACC = 2'b11} op_t;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           state_q, state_d;
    op_t              op_q, op_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clock) begin
        if (clear) begin
            state_q <= IDLE;
            op_q    <= OP_LOADA;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
        end
    end

    // Strobes depend only on the registered state and latched op; cmd_valid
    // affects the next state alone.
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        cnt_d     = cnt_q;
        cmd_ready = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        RAin      = 1'b0;
        RBin      = 1'b0;
        RZin      = 1'b0;
        RAout     = 1'b0;
        RBout     = 1'b0;
        RZout     = 1'b0;
        case (state_q)
            IDLE: begin
                busy      = 1'b0;
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    op_d  = op_t'(cmd_op);
                    cnt_d = cmd_count;
                    if (op_t'(cmd_op) == OP_ACC && cmd_count == '0)
                        state_d = FIN;
                    else
                        state_d = T1;
                end
            end
            T1: begin
                case (op_q)
                    OP_LOADA: begin
                        RAin    = 1'b1;
                        state_d = FIN;
                    end
                    OP_MOVAB: begin
                        RAout   = 1'b1;
                        RBin    = 1'b1;
                        state_d = FIN;
                    end
                    OP_ADD: begin
                        RAout   = 1'b1;
                        RZin    = 1'b1;
                        state_d = T2;
                    end
                    OP_ACC: begin
                        RBout   = 1'b1;
                        RZin    = 1'b1;
                        state_d = T2;
                    end
                    default: state_d = IDLE;
                endcase
            end
            T2: begin
                case (op_q)
                    OP_ADD: begin
                        RZout   = 1'b1;
                        RBin    = 1'b1;
                        state_d = FIN;
                    end
                    OP_ACC: begin
                        RZout = 1'b1;
                        RBin  = 1'b1;
                        // Saturating decrement: the count never wraps below zero.
                        if (cnt_q != '0)
                            cnt_d = cnt_q - CNT_ONE;
                        if (cnt_q > CNT_ONE)
                            state_d = T1;
                        else
                            state_d = FIN;
                    end
                    default: state_d = IDLE;
                endcase
            end
            FIN: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule
